mem_loader: RTL and testbench
=============================

# mem_loader

Boot-time program loader sitting directly upstream of the `cpu` top level. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them into memory through the CPU's external write port (`Ext_MemWrite`, `Ext_WriteData`, `Ext_DataAdr`). While it does this it holds the CPU in reset, then releases reset once the image is complete. A length header sets the image size, which is bounds-checked against a parameter.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written; must be word-aligned.
- `MAX_WORDS`, default 1024: largest accepted word count.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `rx_data` input 8: incoming byte.
- `rx_valid` input 1: `rx_data` is valid.
- `rx_ready` output 1: loader can accept a byte this cycle.
- `cpu_reset` output 1: drives the `cpu` reset input; active-high; 1 while loading.
- `Ext_MemWrite` output 1: one-cycle write strobe to the CPU external write port.
- `Ext_WriteData` output 32: assembled word.
- `Ext_DataAdr` output 32: byte address of the current word.
- `load_done` output 1: image loaded and CPU released; sticky.
- `load_error` output 1: header count exceeded `MAX_WORDS`; sticky.

## Operation
- States are HDR, DATA, WRITE, RUN and ERR. Reset enters HDR.
- **Byte transfer:** a byte is accepted on a rising edge where `rx_valid && rx_ready`.
  - `rx_ready` is 1 in HDR and DATA only.
  - `rx_ready` is 0 while `reset` is low.
- **Byte order:** a 2-bit byte index selects the lane. The first byte goes to [7:0] and the fourth to [31:24] (little-endian).
- **HDR:** collects 4 bytes into a 32-bit `count`. When the 4th byte is accepted:
  - `count == 0`: go to RUN.
  - `count > MAX_WORDS`: go to ERR.
  - otherwise: go to DATA with `words_left = count`.
- **DATA:** collects 4 bytes into `Ext_WriteData`. The 4th byte moves the FSM to WRITE.
- **WRITE:** lasts exactly one cycle.
  - `Ext_MemWrite = 1`; `Ext_WriteData` and `Ext_DataAdr` are stable for the whole cycle.
  - On exit, `Ext_DataAdr += 4` and `words_left -= 1`.
  - If the decremented `words_left` is 0, go to RUN; else go to DATA.
- **RUN (terminal until reset):**
  - `cpu_reset = 0`, `load_done = 1`, `rx_ready = 0`.
  - All further bytes are ignored.
- **ERR (terminal until reset):**
  - `cpu_reset = 1`, `load_error = 1`, `rx_ready = 0`.
  - No memory writes occur.
- **Address arithmetic:** 32-bit and modulo 2^32. It can only wrap if `BASE_ADDR + 4*MAX_WORDS` exceeds 2^32, which is a configuration error and is not checked.
- **Byte gaps:** `rx_valid` may drop between any bytes. Partial words and partial headers are held indefinitely; there is no timeout.
- **Reset mid-load:** asserting `reset` low at any time aborts the load. All registers return to reset values and the next load restarts at HDR. Memory already written is left as is, with undefined partial contents.

## Timing
- **Reset values (while `reset` low):**
  - `cpu_reset = 1`, `rx_ready = 0`.
  - `Ext_MemWrite = 0`, `Ext_WriteData = 0`, `Ext_DataAdr = BASE_ADDR`.
  - `load_done = 0`, `load_error = 0`.
- **After reset release:** `rx_ready = 1` in the first cycle after `reset` goes high.
- **Write latency:** the write strobe is asserted in the cycle after the edge that accepts the 4th data byte.
- **Byte stall:** the byte presented during a WRITE cycle is not accepted (`rx_ready = 0`). With `rx_valid` held high, a word therefore costs 5 cycles.
- **CPU release:** `cpu_reset` falls in the cycle after the last WRITE cycle. `load_done` rises in the same cycle.
- **Zero-length image:** with `count == 0`, `cpu_reset` falls in the cycle after the 4th header byte is accepted.
- **Interaction with `cpu`:** `cpu` samples `Ext_DataAdr` whenever `cpu_reset` is high, and writes on the `clk` edge at the end of the WRITE cycle. `Ext_DataAdr` keeps its last value in RUN, but `cpu` ignores it there because `cpu_reset` is 0.

## Test plan
- **Zero-length image:** header bytes 00 00 00 00 → no `Ext_MemWrite`; `cpu_reset` 0 and `load_done` 1 one cycle after the 4th byte is accepted.
- **Two-word image, back-to-back:**
  - Stimulus: header 02 00 00 00, then bytes 13 05 10 00 and 6F 00 00 00, with `rx_valid` held high.
  - Required writes: 32'h0010_0513 @ 0x0, then 32'h0000_006F @ 0x4.
  - Each write is a single-cycle strobe, 5 cycles apart.
  - `cpu_reset` falls one cycle after the second strobe.
- **Backpressure and gaps:** the same image with `rx_valid` randomly deasserted between bytes. Required: identical data and addresses, and no extra or duplicated writes.
- **Overflow:**
  - With `MAX_WORDS` = 1024 (4-byte count 1025): `load_error` = 1, `cpu_reset` stays 1, `rx_ready` = 0, no writes.
  - With `MAX_WORDS` = 4 (count 4): all 4 words written at 0x0–0xC, `load_done` = 1.
- **Reset mid-word:** assert `reset` low after 2 data bytes of word 1, then release and send the full two-word image. Required: writes start again at `BASE_ADDR`, the stale partial word is never written, and the final writes match the two-word case.
- **Non-zero base:** `BASE_ADDR` = 32'h100 with a one-word image → write at 0x100; bytes sent after completion are not accepted (`rx_ready` = 0).

Source files
------------

// File: rtl/mem_loader_if.sv
// Byte-stream intake plus CPU external write port and boot status, bundled for the loader.
// master = loader side; slave = byte source / CPU side.
interface mem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        cpu_reset;
    logic        Ext_MemWrite;
    logic [31:0] Ext_WriteData;
    logic [31:0] Ext_DataAdr;
    logic        load_done;
    logic        load_error;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
        output load_done, load_error
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
        input  load_done, load_error
    );
endinterface

// File: rtl/mem_loader.sv
// Boot loader: length header then LE words written to the CPU port; write strobe one cycle after 4th byte.
// Backpressure: rx_ready drops for the one-cycle WRITE and for good in RUN/ERR, so a word costs 5 cycles.
module mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic         clk,
    input  logic         reset,
    mem_loader_if.master bus
);
    typedef enum logic [2:0] {HDR, DATA, WRITE, RUN, ERR} state_t;

    state_t      state;
    logic [1:0]  byteIdx;
    logic [31:0] hdrCount;
    logic [31:0] wordsLeft;
    logic [31:0] wrData;
    logic [31:0] dataAdr;
    logic        rdyReg;
    logic        cpuRst;
    logic        memWr;
    logic        doneReg;
    logic        errReg;

    logic        accept;
    logic [31:0] nextHdr;
    logic [31:0] nextData;

    function automatic logic [31:0] putLane(input logic [31:0] word,
                                            input logic [1:0]  idx,
                                            input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    assign accept   = bus.rx_valid && rdyReg;
    assign nextHdr  = putLane(hdrCount, byteIdx, bus.rx_data);
    assign nextData = putLane(wrData, byteIdx, bus.rx_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HDR;
            byteIdx   <= 2'd0;
            hdrCount  <= 32'd0;
            wordsLeft <= 32'd0;
            wrData    <= 32'd0;
            dataAdr   <= BASE_ADDR;
            rdyReg    <= 1'b1;
            cpuRst    <= 1'b1;
            memWr     <= 1'b0;
            doneReg   <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            case (state)
                HDR: begin
                    if (accept) begin
                        hdrCount <= nextHdr;
                        byteIdx  <= byteIdx + 2'd1;
                        if (byteIdx == 2'd3) begin
                            if (nextHdr == 32'd0) begin
                                state   <= RUN;
                                rdyReg  <= 1'b0;
                                cpuRst  <= 1'b0;
                                doneReg <= 1'b1;
                            end else if (nextHdr > 32'(MAX_WORDS)) begin
                                state  <= ERR;
                                rdyReg <= 1'b0;
                                errReg <= 1'b1;
                            end else begin
                                state     <= DATA;
                                wordsLeft <= nextHdr;
                            end
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        wrData  <= nextData;
                        byteIdx <= byteIdx + 2'd1;
                        if (byteIdx == 2'd3) begin
                            state  <= WRITE;
                            rdyReg <= 1'b0;
                            memWr  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // Address and data stay put through this cycle; the CPU commits on the closing edge.
                    memWr     <= 1'b0;
                    dataAdr   <= dataAdr + 32'd4;
                    wordsLeft <= wordsLeft - 32'd1;
                    if (wordsLeft == 32'd1) begin
                        state   <= RUN;
                        cpuRst  <= 1'b0;
                        doneReg <= 1'b1;
                    end else begin
                        state  <= DATA;
                        rdyReg <= 1'b1;
                    end
                end
                RUN: begin
                    rdyReg <= 1'b0;
                end
                default: begin
                    rdyReg <= 1'b0;
                end
            endcase
        end
    end

    // Gating with reset keeps rx_ready low while held in reset and high right after release.
    assign bus.rx_ready      = rdyReg && reset;
    assign bus.cpu_reset     = cpuRst;
    assign bus.Ext_MemWrite  = memWr;
    assign bus.Ext_WriteData = wrData;
    assign bus.Ext_DataAdr   = dataAdr;
    assign bus.load_done     = doneReg;
    assign bus.load_error    = errReg;
endmodule

// File: tb/tb_mem_loader.sv
// Drives three loader configurations (default, MAX_WORDS=4, BASE_ADDR=0x100) from one byte source
// and checks every write, timing point and status flag against an image-level reference model.
module tb_mem_loader;
    typedef logic [7:0] byteQ_t[$];

    localparam logic [31:0] BASE_P [3] = '{32'h0, 32'h0, 32'h100};
    localparam int unsigned MAXW_P [3] = '{1024, 4, 1024};

    logic       clk;
    logic       rstN;
    logic [7:0] rxData;
    logic       rxValid;
    int         sel;
    int         cyc = 0;

    logic        rdy [3];
    logic        cr  [3];
    logic        mw  [3];
    logic [31:0] wd  [3];
    logic [31:0] da  [3];
    logic        ld  [3];
    logic        le  [3];

    logic [31:0] wrAddr [3][$];
    logic [31:0] wrDat  [3][$];
    int          wrCyc  [3][$];
    int          fallQ  [3][$];
    logic        prevCr [3];

    logic [31:0] expAddr[$];
    logic [31:0] expData[$];
    logic        expDone;
    logic        expErr;

    int nAsserts = 0;
    int nFails   = 0;

    mem_loader_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : gDut
        assign bus[g].rx_data  = rxData;
        assign bus[g].rx_valid = rxValid && (sel == g);
        assign rdy[g] = bus[g].rx_ready;
        assign cr[g]  = bus[g].cpu_reset;
        assign mw[g]  = bus[g].Ext_MemWrite;
        assign wd[g]  = bus[g].Ext_WriteData;
        assign da[g]  = bus[g].Ext_DataAdr;
        assign ld[g]  = bus[g].load_done;
        assign le[g]  = bus[g].load_error;

        mem_loader #(.BASE_ADDR(BASE_P[g]), .MAX_WORDS(MAXW_P[g])) u_dut (
            .clk   (clk),
            .reset (rstN),
            .bus   (bus[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: logs every strobe and every cpu_reset falling transition.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mw[k] === 1'b1) begin
                wrAddr[k].push_back(da[k]);
                wrDat[k].push_back(wd[k]);
                wrCyc[k].push_back(cyc);
            end
            if (prevCr[k] === 1'b1 && cr[k] === 1'b0) fallQ[k].push_back(cyc);
            prevCr[k] = cr[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what a complete image should produce, from the header and word list alone.
    task automatic model(input int k, input byteQ_t img);
        logic [31:0] cnt;
        expAddr.delete();
        expData.delete();
        cnt = {img[3], img[2], img[1], img[0]};
        expErr  = (cnt > 32'(MAXW_P[k]));
        expDone = !expErr;
        if (!expErr) begin
            for (int i = 0; i < int'(cnt); i++) begin
                expAddr.push_back(BASE_P[k] + 32'(4 * i));
                expData.push_back({img[4*i+7], img[4*i+6], img[4*i+5], img[4*i+4]});
            end
        end
    endtask

    function automatic byteQ_t makeImage(input int cnt);
        byteQ_t q;
        logic [31:0] c;
        c = 32'(cnt);
        for (int i = 0; i < 4; i++) q.push_back(c[8*i +: 8]);
        for (int i = 0; i < 4 * cnt; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic sendByte(input logic [7:0] b, input int gapMax, output int accCyc);
        int g;
        int waitN;
        if (gapMax > 0) begin
            g = $urandom_range(0, gapMax);
            if (g > 0) begin
                rxValid = 1'b0;
                repeat (g) @(negedge clk);
            end
        end
        rxValid = 1'b1;
        rxData  = b;
        waitN   = 0;
        while (rdy[sel] !== 1'b1 && waitN < 50) begin
            @(negedge clk);
            waitN++;
        end
        check("byte_accept", 32'(rdy[sel]), 32'd1);
        accCyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic doReset();
        rxValid = 1'b0;
        rstN    = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_cpu_reset", 32'(cr[k]), 32'd1);
            check("rst_rx_ready", 32'(rdy[k]), 32'd0);
            check("rst_memwrite", 32'(mw[k]), 32'd0);
            check("rst_wdata", wd[k], 32'd0);
            check("rst_addr", da[k], BASE_P[k]);
            check("rst_done", 32'(ld[k]), 32'd0);
            check("rst_error", 32'(le[k]), 32'd0);
        end
        rstN = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check("ready_after_reset", 32'(rdy[k]), 32'd1);
    endtask

    task automatic runImage(input int k, input byteQ_t img, input int gapMax, input int sw);
        int acc[$];
        int a;
        int sf;
        int nw;
        int nf;
        int expRel;
        sel = k;
        sf  = fallQ[k].size();
        foreach (img[i]) begin
            sendByte(img[i], gapMax, a);
            acc.push_back(a);
        end
        rxValid = 1'b0;
        repeat (3) @(negedge clk);

        model(k, img);
        nw = wrAddr[k].size() - sw;
        check("write_count", 32'(nw), 32'(expAddr.size()));
        for (int i = 0; i < expAddr.size() && i < nw; i++) begin
            check("write_addr", wrAddr[k][sw+i], expAddr[i]);
            check("write_data", wrDat[k][sw+i], expData[i]);
            check("write_latency", 32'(wrCyc[k][sw+i]), 32'(acc[7+4*i]));
        end
        check("load_done", 32'(ld[k]), 32'(expDone));
        check("load_error", 32'(le[k]), 32'(expErr));
        check("cpu_reset", 32'(cr[k]), 32'(!expDone));
        check("rx_ready_terminal", 32'(rdy[k]), 32'd0);
        nf = fallQ[k].size() - sf;
        check("release_count", 32'(nf), expDone ? 32'd1 : 32'd0);
        if (expDone && nf > 0) begin
            expRel = (expAddr.size() == 0) ? acc[3] : acc[acc.size()-1] + 1;
            check("release_cycle", 32'(fallQ[k][sf]), 32'(expRel));
        end
    endtask

    task automatic probeIgnored(input int k);
        int sw;
        sw = wrAddr[k].size();
        sel = k;
        rxValid = 1'b1;
        rxData  = 8'hA5;
        repeat (4) begin
            @(negedge clk);
            check("ignored_rx_ready", 32'(rdy[k]), 32'd0);
        end
        rxValid = 1'b0;
        repeat (2) @(negedge clk);
        check("ignored_no_write", 32'(wrAddr[k].size()), 32'(sw));
    endtask

    initial begin
        byteQ_t two;
        byteQ_t img;
        int sw;
        int a;
        int k;
        int maxc;

        two = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) prevCr[i] = 1'b1;
        rstN    = 1'b0;
        rxValid = 1'b0;
        rxData  = 8'h00;
        sel     = 0;
        @(negedge clk);

        doReset();
        runImage(0, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, wrAddr[0].size());

        doReset();
        sw = wrAddr[0].size();
        runImage(0, two, 0, sw);
        if (wrAddr[0].size() >= sw + 2) begin
            check("b2b_word0", wrDat[0][sw], 32'h0010_0513);
            check("b2b_word1", wrDat[0][sw+1], 32'h0000_006F);
            check("b2b_spacing", 32'(wrCyc[0][sw+1] - wrCyc[0][sw]), 32'd5);
        end

        doReset();
        runImage(0, two, 3, wrAddr[0].size());

        doReset();
        runImage(0, '{8'h01, 8'h04, 8'h00, 8'h00}, 0, wrAddr[0].size());
        probeIgnored(0);

        doReset();
        runImage(1, makeImage(4), 2, wrAddr[1].size());

        doReset();
        runImage(1, '{8'h05, 8'h00, 8'h00, 8'h00}, 1, wrAddr[1].size());

        doReset();
        runImage(2, makeImage(1), 1, wrAddr[2].size());
        probeIgnored(2);

        doReset();
        sel = 0;
        sw  = wrAddr[0].size();
        for (int i = 0; i < 6; i++) sendByte(two[i], 0, a);
        rxValid = 1'b0;
        doReset();
        runImage(0, two, 0, sw);

        for (int t = 0; t < 5; t++) begin
            doReset();
            k    = $urandom_range(0, 2);
            maxc = (MAXW_P[k] < 6) ? int'(MAXW_P[k]) : 6;
            img  = makeImage($urandom_range(0, maxc));
            runImage(k, img, $urandom_range(0, 3), wrAddr[k].size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
